// File: rtl/wb_reg_arbiter.sv
// Two-master round-robin arbiter in front of a pipelined Wishbone register slave.
// One access in flight at a time; a stuck slave is answered with err after TIMEOUT_CYCLES.
module wb_reg_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  input  logic                    m0_wb_we_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  output logic                    m0_wb_rty_o,
  output logic                    m0_wb_stall_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  input  logic                    m1_wb_we_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic                    m1_wb_rty_o,
  output logic                    m1_wb_stall_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  input  logic                    s_wb_ack_i,
  input  logic                    s_wb_err_i,
  input  logic                    s_wb_rty_i,
  input  logic                    s_wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int unsigned SelW = DATA_WIDTH / 8;
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [1:0]             grant_q, grant_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic [1:0]             ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [1:0][DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                   tmo_q, tmo_d;

  logic req0, req1, win, accept, own_cyc, s_resp;

  assign req0    = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1    = m1_wb_cyc_i & m1_wb_stb_i;
  // On a tie the master that was not served last wins.
  assign win     = (req0 & req1) ? ~last_q : req1;
  assign accept  = (state_q == StIdle) & (req0 | req1) & ~rst_i;
  assign own_cyc = owner_q ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign s_resp  = s_wb_ack_i | s_wb_err_i | s_wb_rty_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    ack_d   = '0;
    err_d   = '0;
    rty_d   = '0;
    rdat_d  = '0;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = win;
          grant_d = win ? 2'b10 : 2'b01;
          adr_d   = win ? m1_wb_adr_i : m0_wb_adr_i;
          sel_d   = win ? m1_wb_sel_i : m0_wb_sel_i;
          we_d    = win ? m1_wb_we_i  : m0_wb_we_i;
          wdat_d  = win ? m1_wb_dat_i : m0_wb_dat_i;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (!own_cyc) begin
          state_d = StIdle;
          grant_d = '0;
          last_d  = owner_q;
        end else if (s_resp && (state_q == StWait || !s_wb_stall_i)) begin
          state_d = StResp;
          if (s_wb_err_i) begin
            err_d[owner_q] = 1'b1;
          end else if (s_wb_rty_i) begin
            rty_d[owner_q] = 1'b1;
          end else begin
            ack_d[owner_q] = 1'b1;
            if (!we_q) rdat_d[owner_q] = s_wb_dat_i;
          end
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          state_d        = StResp;
          err_d[owner_q] = 1'b1;
          tmo_d          = 1'b1;
        end else if (state_q == StIssue && !s_wb_stall_i) begin
          state_d = StWait;
        end
      end
      StResp: begin
        state_d = StIdle;
        grant_d = '0;
        last_d  = owner_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rty_q   <= '0;
      rdat_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      rdat_q  <= rdat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign s_wb_cyc_o    = (state_q == StIssue) | (state_q == StWait);
  assign s_wb_stb_o    = (state_q == StIssue);
  assign s_wb_we_o     = we_q;
  assign s_wb_adr_o    = adr_q;
  assign s_wb_sel_o    = sel_q;
  assign s_wb_dat_o    = wdat_q;
  assign grant_o       = grant_q;
  assign timeout_o     = tmo_q;

  assign m0_wb_ack_o   = ack_q[0];
  assign m0_wb_err_o   = err_q[0];
  assign m0_wb_rty_o   = rty_q[0];
  assign m0_wb_dat_o   = rdat_q[0];
  assign m0_wb_stall_o = req0 & ~(accept & ~win);
  assign m1_wb_ack_o   = ack_q[1];
  assign m1_wb_err_o   = err_q[1];
  assign m1_wb_rty_o   = rty_q[1];
  assign m1_wb_dat_o   = rdat_q[1];
  assign m1_wb_stall_o = req1 & ~(accept & win);

endmodule
